// File: rtl/sevenseg_mux_if.sv
// Register-bus interface of the seven-segment controller: write strobe/address/data
// plus a registered read port.
interface sevenseg_mux_if #(
    parameter int DIGITS = 3
);
    localparam int AW = $clog2(DIGITS + 2);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;

    modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
    modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/sevenseg_mux.sv
// Multiplexed N-digit seven-segment controller with per-digit hex decode, PWM
// brightness, register read-back and a once-per-scan frame pulse.
module sevenseg_mux #(
    parameter int DIGITS      = 3,
    parameter int CLK_HZ      = 100000000,
    parameter int SCAN_HZ     = 1000,
    parameter int PWM_BITS    = 4,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit EN_ACT_LOW  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    sevenseg_mux_if.slave     bus,
    output logic [7:0]        ss,
    output logic [DIGITS-1:0] ssen,
    output logic              frame
);
    localparam int TICK_DIV = CLK_HZ / (SCAN_HZ * DIGITS);
    localparam int AW       = $clog2(DIGITS + 2);
    localparam int DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [DW-1:0]       DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [IW-1:0]       IDX_LAST = IW'(DIGITS - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
    // Inactive levels; XOR with these also converts active-high patterns to pin polarity.
    localparam logic [7:0]        SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] EN_OFF  = EN_ACT_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [7:0]          digit_r [DIGITS];
    logic [DIGITS-1:0]   mask_r;
    logic [PWM_BITS-1:0] bright_r;
    logic [DW-1:0]       div_cnt_r;
    logic [IW-1:0]       idx_r;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic                wrap_r;

    logic                tick_s;
    logic                lit_s;
    logic [7:0]          cur_data_s;
    logic                cur_hex_s;
    logic [DIGITS-1:0]   en_s;
    logic [7:0]          seg_s;
    logic [7:0]          rd_s;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'h3F;
            4'h1:    hex7 = 7'h06;
            4'h2:    hex7 = 7'h5B;
            4'h3:    hex7 = 7'h4F;
            4'h4:    hex7 = 7'h66;
            4'h5:    hex7 = 7'h6D;
            4'h6:    hex7 = 7'h7D;
            4'h7:    hex7 = 7'h07;
            4'h8:    hex7 = 7'h7F;
            4'h9:    hex7 = 7'h6F;
            4'hA:    hex7 = 7'h77;
            4'hB:    hex7 = 7'h7C;
            4'hC:    hex7 = 7'h39;
            4'hD:    hex7 = 7'h5E;
            4'hE:    hex7 = 7'h79;
            4'hF:    hex7 = 7'h71;
            default: hex7 = 7'h00;
        endcase
    endfunction

    // Current-digit selection, segment source, PWM gate and read mux.
    always_comb begin
        tick_s     = (div_cnt_r == DIV_LAST);
        lit_s      = (bright_r == PWM_MAX) || (pwm_cnt_r < bright_r);
        cur_data_s = 8'h00;
        cur_hex_s  = 1'b0;
        en_s       = {DIGITS{1'b0}};
        rd_s       = 8'h00;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_r == IW'(i)) begin
                cur_data_s = digit_r[i];
                cur_hex_s  = mask_r[i];
                en_s[i]    = 1'b1;
            end else begin
                en_s[i]    = 1'b0;
            end
            if (bus.rd_addr == AW'(i)) begin
                rd_s = digit_r[i];
            end else begin
                rd_s = rd_s;
            end
        end
        if (bus.rd_addr == AW'(DIGITS)) begin
            rd_s = 8'(mask_r);
        end else if (bus.rd_addr == AW'(DIGITS + 1)) begin
            rd_s = 8'(bright_r);
        end else begin
            rd_s = rd_s;
        end
        if (cur_hex_s) begin
            seg_s = {cur_data_s[7], hex7(cur_data_s[3:0])};
        end else begin
            seg_s = cur_data_s;
        end
    end

    // Scan divider, digit index, PWM counter and register writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DIGITS; i++) begin
                digit_r[i] <= 8'h00;
            end
            mask_r    <= {DIGITS{1'b0}};
            bright_r  <= PWM_MAX;
            div_cnt_r <= {DW{1'b0}};
            idx_r     <= {IW{1'b0}};
            pwm_cnt_r <= {PWM_BITS{1'b0}};
            wrap_r    <= 1'b0;
        end else begin
            div_cnt_r <= tick_s ? {DW{1'b0}} : div_cnt_r + DW'(1);
            if (tick_s) begin
                idx_r <= (idx_r == IDX_LAST) ? {IW{1'b0}} : idx_r + IW'(1);
            end
            pwm_cnt_r <= pwm_cnt_r + PWM_ONE;
            wrap_r    <= tick_s && (idx_r == IDX_LAST);
            if (bus.wr_en) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (bus.wr_addr == AW'(i)) begin
                        digit_r[i] <= bus.wr_data;
                    end
                end
                if (bus.wr_addr == AW'(DIGITS)) begin
                    mask_r <= bus.wr_data[DIGITS-1:0];
                end
                if (bus.wr_addr == AW'(DIGITS + 1)) begin
                    bright_r <= bus.wr_data[PWM_BITS-1:0];
                end
            end
        end
    end

    // Registered pin drivers and read data; frame is delayed to line up with ssen.
    always_ff @(posedge clk) begin
        if (reset) begin
            ss          <= SEG_OFF;
            ssen        <= EN_OFF;
            frame       <= 1'b0;
            bus.rd_data <= 8'h00;
        end else begin
            frame       <= wrap_r;
            bus.rd_data <= rd_s;
            if (lit_s) begin
                ss   <= seg_s ^ SEG_OFF;
                ssen <= en_s ^ EN_OFF;
            end else begin
                ss   <= SEG_OFF;
                ssen <= EN_OFF;
            end
        end
    end
endmodule

// File: tb/tb_sevenseg_mux.sv
// Scoreboard bench for sevenseg_mux (3 digits, 10-cycle slots, 4-bit PWM).
module tb_sevenseg_mux;
    localparam int K_SS = 0, K_EN = 1, K_FR = 2, K_RD = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ss;
    logic [2:0] ssen;
    logic       frame;

    sevenseg_mux_if #(.DIGITS(3)) bus ();

    sevenseg_mux #(
        .DIGITS(3), .CLK_HZ(3000), .SCAN_HZ(100), .PWM_BITS(4),
        .SEG_ACT_LOW(1'b1), .EN_ACT_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .ss(ss), .ssen(ssen), .frame(frame)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        int         kind;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    int         r_edge = 0;
    int         bright_model = 15;
    logic [7:0] seg_model [3];

    task automatic push(input int due, input int kind, input logic [7:0] exp, input string name);
        exp_t e;
        int   pos;
        e.due = due; e.kind = kind; e.exp = exp; e.name = name;
        pos = sb.size();
        while (pos > 0 && sb[pos-1].due > due) pos--;
        sb.insert(pos, e);
    endtask

    function automatic bit lit_at(input int e);
        return (bright_model == 15) || (((e - r_edge) % 16) < bright_model);
    endfunction

    function automatic int idx_at(input int e);
        return ((e - r_edge) / 10) % 3;
    endfunction

    task automatic expect_outputs(input int first, input int n, input string name);
        logic [2:0] oh;
        int         e;
        for (int k = 0; k < n; k++) begin
            e  = first + k;
            oh = 3'b001 << idx_at(e);
            push(e, K_SS, lit_at(e) ? seg_model[idx_at(e)] : 8'hFF, {name, "_ss"});
            push(e, K_EN, lit_at(e) ? {5'b00000, ~oh} : 8'h07, {name, "_ssen"});
            push(e, K_FR, ((e > r_edge) && ((e - r_edge) % 30 == 0)) ? 8'h01 : 8'h00, {name, "_frame"});
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [2:0] addr, input logic [7:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        step(1);
        bus.wr_en   = 1'b0;
    endtask

    task automatic read_check(input logic [2:0] addr, input logic [7:0] exp, input string name);
        bus.rd_addr = addr;
        step(1);
        push(cyc, K_RD, exp, name);
    endtask

    // Monitor: compares every queued expectation whose cycle has come up.
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                case (e.kind)
                    K_SS:    act = ss;
                    K_EN:    act = {5'b00000, ssen};
                    K_FR:    act = {7'b0000000, frame};
                    K_RD:    act = bus.rd_data;
                    default: act = 8'h00;
                endcase
                checks++;
                if (e.due != cyc || act !== e.exp) begin
                    failures++;
                    $display("FAIL %s cycle=%0d due=%0d actual=%h expected=%h", e.name, cyc, e.due, act, e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = 3'd0;
        bus.wr_data = 8'h00;
        bus.rd_addr = 3'd0;
        for (int i = 0; i < 3; i++) seg_model[i] = 8'hFF;

        // Reset values and scan order/frame timing with all-zero data
        reset = 1'b1;
        step(3);
        push(cyc, K_SS, 8'hFF, "reset_ss");
        push(cyc, K_EN, 8'h07, "reset_ssen");
        push(cyc, K_FR, 8'h00, "reset_frame");
        push(cyc, K_RD, 8'h00, "reset_rd");
        reset  = 1'b0;
        r_edge = cyc + 1;
        expect_outputs(r_edge, 45, "scan");
        step(45);

        // Hex decode of digits 0 and 1
        write(3'd3, 8'h03);
        write(3'd0, 8'h05);
        write(3'd1, 8'h8A);
        seg_model[0] = 8'h92;
        seg_model[1] = 8'h08;
        expect_outputs(cyc + 1, 40, "hex");
        step(40);

        // Brightness 4, 0 and F
        write(3'd4, 8'h04);
        bright_model = 4;
        expect_outputs(cyc + 1, 48, "pwm4");
        step(48);
        write(3'd4, 8'h00);
        bright_model = 0;
        expect_outputs(cyc + 1, 20, "pwm0");
        step(20);
        write(3'd4, 8'h0F);
        bright_model = 15;
        expect_outputs(cyc + 1, 20, "pwmF");
        step(20);

        // Read-back, read/write collision and unmapped addresses
        write(3'd2, 8'h5A);
        seg_model[2] = 8'hA5;
        read_check(3'd2, 8'h5A, "rd_digit2");
        bus.rd_addr = 3'd0;
        write(3'd0, 8'h11);
        push(cyc, K_RD, 8'h05, "rd_collide_old");
        step(1);
        push(cyc, K_RD, 8'h11, "rd_collide_new");
        seg_model[0] = 8'hF9;
        read_check(3'd3, 8'h03, "rd_mask");
        read_check(3'd4, 8'h0F, "rd_bright");
        read_check(3'd5, 8'h00, "rd_addr5");
        read_check(3'd7, 8'h00, "rd_addr7");
        write(3'd5, 8'hFF);
        read_check(3'd0, 8'h11, "rd_after_w5_d0");
        read_check(3'd1, 8'h8A, "rd_after_w5_d1");
        read_check(3'd2, 8'h5A, "rd_after_w5_d2");
        read_check(3'd3, 8'h03, "rd_after_w5_mask");
        read_check(3'd4, 8'h0F, "rd_after_w5_bright");
        expect_outputs(cyc + 1, 30, "post");
        step(30);

        // One-cycle reset in the middle of digit 1
        begin
            int g;
            g = 0;
            while (!((idx_at(cyc + 1) == 1) && (((cyc + 1 - r_edge) % 10) == 5)) && g < 100) begin
                step(1);
                g++;
            end
        end
        reset = 1'b1;
        step(1);
        push(cyc, K_SS, 8'hFF, "midreset_ss");
        push(cyc, K_EN, 8'h07, "midreset_ssen");
        push(cyc, K_FR, 8'h00, "midreset_frame");
        push(cyc, K_RD, 8'h00, "midreset_rd");
        reset  = 1'b0;
        r_edge = cyc + 1;
        for (int i = 0; i < 3; i++) seg_model[i] = 8'hFF;
        bright_model = 15;
        expect_outputs(r_edge, 35, "restart");
        read_check(3'd0, 8'h00, "rst_rd_d0");
        read_check(3'd1, 8'h00, "rst_rd_d1");
        read_check(3'd2, 8'h00, "rst_rd_d2");
        read_check(3'd3, 8'h00, "rst_rd_mask");
        read_check(3'd4, 8'h0F, "rst_rd_bright");
        step(32);

        begin
            int g;
            g = 0;
            while (sb.size() > 0 && g < 100) begin
                step(1);
                g++;
            end
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
